// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage: PC generation, imem requests, response
//             FIFO, redirect flush and ecall halt. Define FETCH_STATS_EN to add
//             the stat_fetched/stat_flushed counters.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  output logic            is_halted
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]     stat_fetched,
  output logic [31:0]     stat_flushed
`endif
);

  localparam int unsigned     c_AW      = $clog2(QDEPTH);
  localparam int unsigned     c_CW      = $clog2(QDEPTH) + 1;
  localparam logic [c_CW:0]   c_QD      = QDEPTH[c_CW:0];
  localparam logic [c_AW-1:0] c_PTR_ONE = {{(c_AW-1){1'b0}}, 1'b1};
  localparam logic [c_CW-1:0] c_CNT_ONE = {{(c_CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] c_ALIGN   = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_run;
  logic [XLEN-1:0] r_fetch_pc;
  logic [c_CW-1:0] r_fifo_cnt, r_outstanding, r_drop;
  logic [c_AW-1:0] r_fifo_wr, r_fifo_rd, r_pcq_wr, r_pcq_rd;
  logic [XLEN-1:0] r_fifo_inst [QDEPTH];
  logic [XLEN-1:0] r_fifo_pc   [QDEPTH];
  logic [XLEN-1:0] r_pcq       [QDEPTH];

  logic            w_acc, w_pop, w_redirect, w_resp_live, w_resp_drop, w_push;
  logic [c_CW:0]   w_inflight;
  logic [c_CW-1:0] w_acc_n, w_push_n, w_pop_n, w_out_nxt, w_drop_nxt;

  assign w_inflight     = {1'b0, r_fifo_cnt} + {1'b0, r_outstanding};
  assign imem_req_valid = r_run && (r_state == S_FETCH) && (w_inflight < c_QD);
  assign imem_req_addr  = r_fetch_pc;
  assign inst_valid     = (r_fifo_cnt != '0);
  assign inst_out       = inst_valid ? r_fifo_inst[r_fifo_rd] : '0;
  assign inst_pc        = inst_valid ? r_fifo_pc[r_fifo_rd]   : '0;
  assign is_halted      = (r_state == S_HALTED);

  assign w_acc       = imem_req_valid && imem_req_ready;
  assign w_pop       = inst_valid && inst_ready;
  assign w_redirect  = redirect_valid && r_run && (r_state != S_HALTED);
  // Responses with nothing in flight and nothing to drop are protocol errors.
  assign w_resp_live = imem_resp_valid && ((r_drop != '0) || (r_outstanding != '0));
  assign w_resp_drop = imem_resp_valid &&
                       ((r_drop != '0) || (w_redirect && (r_outstanding != '0)));
  assign w_push      = w_resp_live && !w_resp_drop;

  assign w_acc_n  = {{(c_CW-1){1'b0}}, w_acc};
  assign w_push_n = {{(c_CW-1){1'b0}}, w_push};
  assign w_pop_n  = {{(c_CW-1){1'b0}}, w_pop};

  always_comb begin
    w_drop_nxt = r_drop;
    w_out_nxt  = r_outstanding + w_acc_n - w_push_n;
    if (w_redirect) begin
      w_drop_nxt = r_drop + r_outstanding + w_acc_n;
      w_out_nxt  = '0;
    end
    if (w_resp_drop) begin
      w_drop_nxt = w_drop_nxt - c_CNT_ONE;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: begin
        if (halt_req && r_run) begin
          w_state_nxt = ((r_outstanding != '0) || w_acc) ? S_DRAIN : S_HALTED;
        end
      end
      S_DRAIN: begin
        if (!w_redirect && (w_out_nxt == '0)) begin
          w_state_nxt = S_HALTED;
        end
      end
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_FETCH;
      r_run         <= 1'b0;
      r_fetch_pc    <= RESET_PC;
      r_fifo_cnt    <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_fifo_wr     <= '0;
      r_fifo_rd     <= '0;
      r_pcq_wr      <= '0;
      r_pcq_rd      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_run         <= 1'b1;
      r_outstanding <= w_out_nxt;
      r_drop        <= w_drop_nxt;
      if (w_redirect) begin
        r_fetch_pc <= redirect_pc & c_ALIGN;
        r_fifo_cnt <= '0;
        r_fifo_wr  <= '0;
        r_fifo_rd  <= '0;
        r_pcq_wr   <= '0;
        r_pcq_rd   <= '0;
      end else begin
        if (w_acc) begin
          r_fetch_pc <= r_fetch_pc + c_PC_STEP;
          r_pcq_wr   <= r_pcq_wr + c_PTR_ONE;
        end
        if (w_push) begin
          r_pcq_rd  <= r_pcq_rd + c_PTR_ONE;
          r_fifo_wr <= r_fifo_wr + c_PTR_ONE;
        end
        if (w_pop) begin
          r_fifo_rd <= r_fifo_rd + c_PTR_ONE;
        end
        r_fifo_cnt <= r_fifo_cnt + w_push_n - w_pop_n;
      end
    end
  end

  // Storage needs no reset: contents are masked until the count covers them.
  always_ff @(posedge clk) begin
    if (w_acc && !w_redirect) begin
      r_pcq[r_pcq_wr] <= r_fetch_pc;
    end
    if (w_push) begin
      r_fifo_inst[r_fifo_wr] <= imem_resp_data;
      r_fifo_pc[r_fifo_wr]   <= r_pcq[r_pcq_rd];
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0]     r_stat_fetched, r_stat_flushed;
  logic [c_CW-1:0] w_flush_fifo;
  logic [32:0]     w_fetched_sum, w_flushed_sum;

  // A pop in the redirect cycle counts as delivered, not flushed.
  assign w_flush_fifo  = w_redirect ? (r_fifo_cnt - w_pop_n) : '0;
  assign w_fetched_sum = {1'b0, r_stat_fetched} + {32'd0, w_pop};
  assign w_flushed_sum = {1'b0, r_stat_flushed} + 33'(w_flush_fifo) + {32'd0, w_resp_drop};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_fetched <= '0;
      r_stat_flushed <= '0;
    end else begin
      r_stat_fetched <= w_fetched_sum[32] ? 32'hFFFF_FFFF : w_fetched_sum[31:0];
      r_stat_flushed <= w_flushed_sum[32] ? 32'hFFFF_FFFF : w_flushed_sum[31:0];
    end
  end

  assign stat_fetched = r_stat_fetched;
  assign stat_flushed = r_stat_flushed;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit with an imem model and an
//             in-order expected-instruction scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_out, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req, is_halted;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_flushed;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .QDEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .is_halted(is_halted)
`ifdef FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
`endif
  );

  typedef struct packed {logic [31:0] inst; logic [31:0] pc;} exp_t;
  typedef struct {logic [31:0] data; int epoch; int due;} req_t;
  typedef struct {bit rst; int cycles; bit rdy; int lat; bit irdy; int exp_acc; int exp_rv;} vec_t;

  exp_t        exp_q[$];
  req_t        pend[$];
  vec_t        vt[5];
  int          n_vec = 0, n_err = 0;
  int          cyc = 0, epoch = 0, avail = 0, last_due = 0, n_acc = 0, n_pop = 0;
  logic [31:0] exp_addr = RESET_PC;
  bit          cfg_rdy = 1'b0, cfg_irdy = 1'b0, p_redir = 1'b0, p_halt = 1'b0, model_halted = 1'b0;
  int          cfg_lat = 1;
  logic [31:0] p_redir_pc = '0;

  function automatic logic [31:0] idata(input logic [31:0] a);
    return ~a ^ 32'h1357_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs at the negedge, sample handshakes, advance.
  task automatic tick();
    req_t r;
    bit   got, redir_eff;
    exp_t e;
    imem_req_ready = cfg_rdy;
    inst_ready     = cfg_irdy;
    redirect_valid = p_redir;
    redirect_pc    = p_redir_pc;
    halt_req       = p_halt;
    got = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      r   = pend.pop_front();
      got = 1'b1;
    end
    imem_resp_valid = got;
    imem_resp_data  = got ? r.data : $urandom();
    redir_eff = p_redir && !model_halted;
    #1;
    chk("inst_valid", inst_valid, avail > 0);
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_addr);
      last_due = (cyc + cfg_lat > last_due + 1) ? cyc + cfg_lat : last_due + 1;
      pend.push_back('{data: idata(exp_addr), epoch: epoch, due: last_due});
      if (!redir_eff) exp_q.push_back({idata(exp_addr), exp_addr});
      exp_addr = exp_addr + 32'd4;
      n_acc++;
    end
    if (inst_valid && inst_ready) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL stale_pop: got pc %0h inst %0h expected no instruction", inst_pc, inst_out);
      end else begin
        e = exp_q.pop_front();
        chk("inst_pc", inst_pc, e.pc);
        chk("inst_out", inst_out, e.inst);
      end
      if (avail > 0) avail--;
    end
    if (got && r.epoch == epoch && !redir_eff) avail++;
    if (redir_eff) begin
      exp_q.delete();
      avail = 0;
      epoch++;
      exp_addr = p_redir_pc & ~32'h3;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    p_redir = 1'b0;
    p_halt  = 1'b0;
    redirect_valid = 1'b0;
    halt_req = 1'b0;
  endtask

  task automatic do_reset(input bit keep_pending);
    reset = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; halt_req = 1'b0;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_out", inst_out, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_is_halted", is_halted, 0);
    epoch++;
    exp_q.delete();
    avail = 0; n_pop = 0;
    exp_addr = RESET_PC;
    model_halted = 1'b0;
    if (!keep_pending) pend.delete();
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, RESET_PC);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!inst_valid && k < 20) begin
      tick();
      k++;
    end
    if (!inst_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: inst_valid got 0 expected 1 within 20 cycles", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;

    //        rst cyc rdy lat irdy accepts req_valid_end
    vt[0] = '{1'b1, 12, 1'b1, 1, 1'b1, 8, -1};
    vt[1] = '{1'b1, 10, 1'b1, 1, 1'b0, 2,  0};
    vt[2] = '{1'b0,  8, 1'b1, 1, 1'b1, 5, -1};
    vt[3] = '{1'b0, 10, 1'b0, 1, 1'b1, 0,  1};
    vt[4] = '{1'b0, 20, 1'b1, 3, 1'b1, -1, -1};

    #2;
    for (int i = 0; i < 5; i++) begin
      if (vt[i].rst) do_reset(1'b0);
      cfg_rdy = vt[i].rdy; cfg_lat = vt[i].lat; cfg_irdy = vt[i].irdy;
      n_acc = 0;
      repeat (vt[i].cycles) tick();
      if (vt[i].exp_acc >= 0) chk($sformatf("row%0d_accepts", i), n_acc, vt[i].exp_acc);
      if (vt[i].exp_rv >= 0) chk($sformatf("row%0d_req_valid", i), imem_req_valid, vt[i].exp_rv);
    end

    // Redirect to an unaligned target with two slow requests in flight.
    do_reset(1'b0);
    cfg_rdy = 1'b1; cfg_lat = 3; cfg_irdy = 1'b1;
    tick(); tick();
    chk("a_req_blocked", imem_req_valid, 0);
    p_redir = 1'b1; p_redir_pc = 32'h103; cfg_irdy = 1'b0;
    tick();
    wait_valid("a_wait");
    chk("a_first_pc", inst_pc, 32'h100);
    cfg_irdy = 1'b1;
    repeat (6) tick();

    // Redirect coinciding with a request accept and a response.
    do_reset(1'b0);
    cfg_rdy = 1'b1; cfg_lat = 1; cfg_irdy = 1'b1;
    tick();
    p_redir = 1'b1; p_redir_pc = 32'h40;
    tick();
    tick(); tick();
`ifdef FETCH_STATS_EN
    chk("b_stat_flushed", stat_flushed, 2);
`endif
    cfg_irdy = 1'b0;
    wait_valid("b_wait");
    chk("b_first_pc", inst_pc, 32'h40);
    cfg_irdy = 1'b1;
    repeat (6) tick();

    // Halt with one request outstanding.
    do_reset(1'b0);
    cfg_rdy = 1'b1; cfg_lat = 2; cfg_irdy = 1'b0;
    tick();
    cfg_rdy = 1'b0; p_halt = 1'b1;
    tick();
    chk("c_drain_req_valid", imem_req_valid, 0);
    chk("c_drain_halted", is_halted, 0);
    tick();
    chk("c_halted", is_halted, 1);
    model_halted = 1'b1;
    cfg_rdy = 1'b1; p_redir = 1'b1; p_redir_pc = 32'h200;
    tick();
    chk("c_halted_after_redirect", is_halted, 1);
    chk("c_halted_req_valid", imem_req_valid, 0);
    cfg_irdy = 1'b1;
    repeat (4) tick();
    chk("c_drained", inst_valid, 0);
    chk("c_still_halted", is_halted, 1);

    // Reset asserted with a buffered instruction and a response still pending.
    do_reset(1'b0);
    cfg_rdy = 1'b1; cfg_lat = 3; cfg_irdy = 1'b0;
    repeat (4) tick();
    chk("d_valid_before_reset", inst_valid, 1);
    do_reset(1'b1);
    cfg_rdy = 1'b1; cfg_lat = 1; cfg_irdy = 1'b1;
    repeat (10) tick();
`ifdef FETCH_STATS_EN
    chk("d_stat_fetched", stat_fetched, n_pop);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
